serial_add_seq: RTL and testbench

//  Bit-serial N-bit adder sequencer. It drives one external 1-bit full-adder cell
//  (FA_Y = FA_A + FA_B + FA_C) LSB-first, one bit per clock, and registers the

---
 rtl/serial_add_seq.sv | 85 ++++++++
 tb/tb_serial_add_seq.sv | 191 +++++++++++++++++++
 2 files changed

// File: rtl/serial_add_seq.sv
// Bit-serial N-bit adder sequencer driving an external 1-bit full-adder cell,
// LSB-first, one bit per clock, with the carry held in a register between bits.
module serial_add_seq #(
    parameter int N = 8
) (
    input  logic         CLK,
    input  logic         N_RESET,
    input  logic         START,
    input  logic [N-1:0] A,
    input  logic [N-1:0] B,
    input  logic         CIN,
    input  logic [1:0]   FA_Y,
    output logic         FA_A,
    output logic         FA_B,
    output logic         FA_C,
    output logic         BUSY,
    output logic         DONE,
    output logic [N-1:0] SUM,
    output logic         COUT
);

    localparam int CW = (N > 2) ? $clog2(N) : 1;
    localparam logic [CW-1:0] LAST_BIT = CW'(N - 1);

    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] SHIFT = 2'd1;
    localparam logic [1:0] FIN   = 2'd2;

    logic [1:0]    state;
    logic [N-1:0]  a_sh;
    logic [N-1:0]  b_sh;
    logic [N-1:0]  s_sh;
    logic          carry;
    logic [CW-1:0] cnt;

    always_ff @(posedge CLK) begin
        if (!N_RESET) begin
            state <= IDLE;
            a_sh  <= '0;
            b_sh  <= '0;
            s_sh  <= '0;
            carry <= 1'b0;
            cnt   <= '0;
            SUM   <= '0;
            COUT  <= 1'b0;
        end else begin
            case (state)
                SHIFT: begin
                    s_sh  <= {FA_Y[0], s_sh[N-1:1]};
                    carry <= FA_Y[1];
                    a_sh  <= {1'b0, a_sh[N-1:1]};
                    b_sh  <= {1'b0, b_sh[N-1:1]};
                    cnt   <= cnt + 1'b1;
                    if (cnt == LAST_BIT) begin
                        // Result registers take the final bit straight from the cell.
                        state <= FIN;
                        SUM   <= {FA_Y[0], s_sh[N-1:1]};
                        COUT  <= FA_Y[1];
                    end
                end
                default: begin
                    // IDLE and FIN both accept a new request.
                    if (START) begin
                        state <= SHIFT;
                        a_sh  <= A;
                        b_sh  <= B;
                        carry <= CIN;
                        cnt   <= '0;
                    end else begin
                        state <= IDLE;
                    end
                end
            endcase
        end
    end

    always_comb begin
        BUSY = (state == SHIFT);
        DONE = (state == FIN);
        FA_A = BUSY & a_sh[0];
        FA_B = BUSY & b_sh[0];
        FA_C = BUSY & carry;
    end

endmodule

// File: tb/tb_serial_add_seq.sv
// Directed bench for serial_add_seq: behavioural full-adder on FA_Y and a
// scoreboard queue filled on accepted START, drained on DONE.
module tb_serial_add_seq;

    localparam int N = 8;

    logic         clk = 1'b0;
    logic         n_reset;
    logic         start;
    logic [N-1:0] a;
    logic [N-1:0] b;
    logic         cin;
    logic [1:0]   fa_y;
    logic         fa_a;
    logic         fa_b;
    logic         fa_c;
    logic         busy;
    logic         done;
    logic [N-1:0] sum;
    logic         cout;

    int unsigned checks = 0;
    int unsigned errors = 0;
    int unsigned cyc = 0;
    int unsigned done_count = 0;
    int unsigned last_done_cyc = 0;
    bit          fac_must_be_one = 1'b0;
    logic [N:0]  sb[$];

    always #5 clk = ~clk;

    assign fa_y = {1'b0, fa_a} + {1'b0, fa_b} + {1'b0, fa_c};

    serial_add_seq #(.N(N)) dut (
        .CLK    (clk),
        .N_RESET(n_reset),
        .START  (start),
        .A      (a),
        .B      (b),
        .CIN    (cin),
        .FA_Y   (fa_y),
        .FA_A   (fa_a),
        .FA_B   (fa_b),
        .FA_C   (fa_c),
        .BUSY   (busy),
        .DONE   (done),
        .SUM    (sum),
        .COUT   (cout)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One clock: record acceptance before the edge, then sample #1 after it.
    task automatic tick();
        logic [N:0] exp_res;
        if (!n_reset) sb.delete();
        else if (start && !busy) sb.push_back({1'b0, a} + {1'b0, b} + {{N{1'b0}}, cin});
        @(posedge clk);
        #1;
        cyc++;
        if (done) begin
            done_count++;
            last_done_cyc = cyc;
            if (sb.size() == 0) begin
                check("unexpected_done", 32'(done), 32'd0);
            end else begin
                exp_res = sb.pop_front();
                check("sb_sum", 32'(sum), 32'(exp_res[N-1:0]));
                check("sb_cout", 32'(cout), 32'(exp_res[N]));
            end
        end
        if (!busy) check("fa_idle_zero", 32'({fa_a, fa_b, fa_c}), 32'd0);
        else if (fac_must_be_one) check("fa_c_one", 32'(fa_c), 32'd1);
    endtask

    task automatic do_add(input logic [N-1:0] av, input logic [N-1:0] bv, input logic cv);
        start = 1'b1; a = av; b = bv; cin = cv;
        tick();
        start = 1'b0; a = '0; b = '0; cin = 1'b0;
        check("busy_after_start", 32'(busy), 32'd1);
        for (int i = 1; i <= N; i++) begin
            tick();
            if (i < N) check("done_early", 32'(done), 32'd0);
            else check("done_latency", 32'(done), 32'd1);
        end
    endtask

    task automatic wait_idle();
        int unsigned n;
        n = 0;
        while (busy && n < 2 * N) begin
            tick();
            n++;
        end
        check("idle_timeout", 32'(busy), 32'd0);
    endtask

    initial begin
        int unsigned dc0;
        n_reset = 1'b0; start = 1'b0; a = '0; b = '0; cin = 1'b0;
        tick();
        tick();
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_sum", 32'(sum), 32'd0);
        check("rst_cout", 32'(cout), 32'd0);
        n_reset = 1'b1;
        tick();

        do_add(8'h5A, 8'h3C, 1'b0);
        check("add_5a_3c_sum", 32'(sum), 32'h96);
        check("add_5a_3c_cout", 32'(cout), 32'd0);
        tick();
        check("sum_hold", 32'(sum), 32'h96);

        do_add(8'hFF, 8'h01, 1'b0);
        check("add_ff_01_sum", 32'(sum), 32'h00);
        check("add_ff_01_cout", 32'(cout), 32'd1);
        tick();

        fac_must_be_one = 1'b1;
        do_add(8'hFF, 8'hFF, 1'b1);
        fac_must_be_one = 1'b0;
        check("add_ff_ff_1_sum", 32'(sum), 32'hFF);
        check("add_ff_ff_1_cout", 32'(cout), 32'd1);
        tick();

        // START while busy must be ignored.
        dc0 = done_count;
        start = 1'b1; a = 8'h01; b = 8'h01; cin = 1'b0;
        tick();
        start = 1'b0;
        tick();
        tick();
        start = 1'b1; a = 8'h11; b = 8'h00;
        tick();
        start = 1'b0; a = '0; b = '0;
        check("sum_hold_during_op", 32'(sum), 32'hFF);
        wait_idle();
        for (int i = 0; i < N + 2; i++) tick();
        check("busy_ignore_sum", 32'(sum), 32'h02);
        check("busy_ignore_single_done", done_count - dc0, 32'd1);

        // Reset mid-operation at SHIFT bit 4.
        dc0 = done_count;
        start = 1'b1; a = 8'h7E; b = 8'h19; cin = 1'b1;
        tick();
        start = 1'b0;
        for (int i = 0; i < 4; i++) tick();
        n_reset = 1'b0;
        tick();
        n_reset = 1'b1;
        check("midrst_busy", 32'(busy), 32'd0);
        check("midrst_done", 32'(done), 32'd0);
        check("midrst_sum", 32'(sum), 32'd0);
        check("midrst_cout", 32'(cout), 32'd0);
        for (int i = 0; i < N + 2; i++) tick();
        check("midrst_no_done", done_count - dc0, 32'd0);
        do_add(8'h33, 8'h44, 1'b0);
        check("after_rst_sum", 32'(sum), 32'h77);
        tick();

        // START held high: back-to-back operations every N+1 cycles.
        dc0 = done_count;
        start = 1'b1; a = 8'h10; b = 8'h20; cin = 1'b0;
        for (int i = 0; i < 3 * (N + 1); i++) begin
            int unsigned prev;
            prev = last_done_cyc;
            tick();
            if (done) begin
                check("b2b_sum", 32'(sum), 32'h30);
                if (done_count - dc0 > 1) check("b2b_interval", last_done_cyc - prev, N + 1);
            end
        end
        start = 1'b0;
        check("b2b_done_count", done_count - dc0, 32'd3);
        wait_idle();
        tick();
        check("sb_empty", 32'(sb.size()), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
